// File: rtl/dmem_pkg.sv
// Shared constants and types for the 72-bit data memory.
// The write-side and read-side modules both import this package.
package dmem_pkg;

   localparam int unsigned DATA_W         = 72;
   localparam int unsigned ADDR_W         = 6;
   localparam int unsigned MEM_DEPTH      = 1 << ADDR_W;
   localparam int unsigned RSP_FIFO_DEPTH = 4;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] addr;
   } rsp_t;

   localparam int unsigned RSP_W = $bits(rsp_t);

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Synchronous FIFO used to hold read responses, without bypass.
// A push into an empty FIFO becomes visible at head on the following cycle.
module dmem_rsp_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A pop on empty is ignored; a push on full is only taken alongside a pop.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

   // NOTE: the data array has no reset; count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         storage[wr_ptr] <= push_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = storage[rd_ptr];

endmodule

// File: rtl/data_memory_reader.sv
// Read-side controller for the data memory: accepts requests, issues synchronous
// reads, forwards same-cycle write data, and returns words in order through a FIFO.
module data_memory_reader
   import dmem_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = RSP_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [15:0]       rd_count
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic              acc;
   logic              pop;
   logic              inflight;
   logic [ADDR_W-1:0] inflight_addr;
   logic              fwd;
   logic [DATA_W-1:0] fwd_data;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W-1:0]  occupancy;
   rsp_t              push_entry;
   rsp_t              head_entry;

   // Reserve a FIFO slot for the in-flight read so the capture push never meets a full FIFO.
   assign occupancy = fifo_count + CNT_W'(inflight);
   assign req_ready = reset && (occupancy < CNT_W'(FIFO_DEPTH));
   assign acc       = req_valid && req_ready;

   assign mem_rd_en   = acc;
   assign mem_rd_addr = acc ? req_addr : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inflight      <= 1'b0;
         inflight_addr <= '0;
         fwd           <= 1'b0;
         fwd_data      <= '0;
      end else begin
         inflight <= acc;
         if (acc) begin
            inflight_addr <= req_addr;
            fwd           <= wr_en && (wr_addr == req_addr);
            fwd_data      <= wr_data;
         end
      end
   end

   // NOTE: combinational logic uses blocking assignments with a default first, so no latch is inferred.
   always_comb begin
      push_entry      = '0;
      push_entry.addr = inflight_addr;
      push_entry.data = fwd ? fwd_data : mem_rd_data;
   end

   dmem_rsp_fifo #(
      .WIDTH (RSP_W),
      .DEPTH (FIFO_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (inflight),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head_entry),
      .count     (fifo_count)
   );

   // Head is masked when empty so the outputs read zero in and right after reset.
   assign rsp_valid = (fifo_count != '0);
   assign rsp_data  = rsp_valid ? head_entry.data : '0;
   assign rsp_addr  = rsp_valid ? head_entry.addr : '0;
   assign pop       = rsp_valid && rsp_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_count <= '0;
      end else if (pop && (rd_count != 16'hFFFF)) begin
         rd_count <= rd_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_data_memory_reader.sv
// Directed self-checking bench for data_memory_reader with a read-before-write
// memory model, so only the reader's forwarding can deliver same-cycle write data.
module tb_data_memory_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_addr;
   logic        mem_rd_en;
   logic [5:0]  mem_rd_addr;
   logic [71:0] mem_rd_data = '0;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [71:0] wr_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [71:0] rsp_data;
   logic [5:0]  rsp_addr;
   logic [15:0] rd_count;

   int checks   = 0;
   int failures = 0;

   logic [71:0] shadow [64];
   logic [71:0] wmem   [64];
   logic [63:0] written = '0;
   int          exp_q [$];
   int          sent;
   int          got;
   int          e;

   always #5 clk = ~clk;

   data_memory_reader dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_addr    (rsp_addr),
      .rd_count    (rd_count)
   );

   function automatic logic [71:0] pat(input int a);
      if (a == 5) return 72'h0A_1234_5678_9ABC_DEF0;
      return {8'(a), 32'hC0DE_5A5A, 26'd0, 6'(a)};
   endfunction

   // Memory array model: synchronous read one cycle after the strobe, old data on a same-cycle write.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= written[mem_rd_addr] ? wmem[mem_rd_addr] : pat(int'(mem_rd_addr));
      if (wr_en) begin
         wmem[wr_addr]    <= wr_data;
         written[wr_addr] <= 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=still_running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      for (int i = 0; i < 64; i++) shadow[i] = pat(i);

      // Reset values, with a request presented while reset is held
      tick(); req_valid = 1'b1; req_addr = 6'd7; settle();
      chk1("reset_rsp_valid", rsp_valid, 1'b0);
      chk1("reset_req_ready", req_ready, 1'b0);
      chk1("reset_mem_rd_en", mem_rd_en, 1'b0);
      chkw("reset_rsp_data", rsp_data, 72'd0);
      chkw("reset_rsp_addr", 72'(rsp_addr), 72'd0);
      chkw("reset_rd_count", 72'(rd_count), 72'd0);
      tick(); req_valid = 1'b0; reset = 1'b1; settle();
      chk1("release_req_ready", req_ready, 1'b1);

      // Single read of word 5
      tick(); req_valid = 1'b1; req_addr = 6'd5; rsp_ready = 1'b1; settle();
      chk1("single_rd_en", mem_rd_en, 1'b1);
      chkw("single_rd_addr", 72'(mem_rd_addr), 72'd5);
      tick(); req_valid = 1'b0; req_addr = 6'd6; settle();
      chk1("single_idle_rd_en", mem_rd_en, 1'b0);
      chkw("single_idle_rd_addr", 72'(mem_rd_addr), 72'd0);
      chk1("single_t1_valid", rsp_valid, 1'b0);
      tick(); settle();
      chk1("single_t2_valid", rsp_valid, 1'b1);
      chkw("single_data", rsp_data, 72'h0A_1234_5678_9ABC_DEF0);
      chkw("single_addr", 72'(rsp_addr), 72'd5);
      tick(); settle();
      chk1("single_drained", rsp_valid, 1'b0);
      chkw("single_rd_count", 72'(rd_count), 72'd1);

      // Backpressure: only four requests fit
      rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(); req_valid = 1'b1; req_addr = 6'(i); settle();
         chk1("bp_req_ready", req_ready, i < 4);
         chk1("bp_rd_en", mem_rd_en, i < 4);
      end
      tick(); req_valid = 1'b0; settle();
      chk1("bp_full_ready", req_ready, 1'b0);
      chk1("bp_hold_valid", rsp_valid, 1'b1);
      chkw("bp_hold_addr0", 72'(rsp_addr), 72'd0);
      tick(); settle();
      chkw("bp_hold_addr1", 72'(rsp_addr), 72'd0);
      chkw("bp_hold_data1", rsp_data, shadow[0]);
      for (int j = 0; j < 4; j++) begin
         tick(); rsp_ready = 1'b1; settle();
         if (j == 0) chk1("bp_ready_no_comb_path", req_ready, 1'b0);
         chk1("bp_drain_valid", rsp_valid, 1'b1);
         chkw("bp_drain_addr", 72'(rsp_addr), 72'(j));
         chkw("bp_drain_data", rsp_data, shadow[j]);
      end
      tick(); settle();
      chk1("bp_empty", rsp_valid, 1'b0);
      chk1("bp_ready_again", req_ready, 1'b1);
      chkw("bp_rd_count", 72'(rd_count), 72'd5);

      // Streaming: 32 back-to-back reads
      for (int c = 0; c < 36; c++) begin
         tick(); req_valid = (c < 32); req_addr = 6'(c); settle();
         if (c < 32) chk1("stream_req_ready", req_ready, 1'b1);
         if (c >= 2 && c < 34) begin
            chk1("stream_valid", rsp_valid, 1'b1);
            chkw("stream_addr", 72'(rsp_addr), 72'(c - 2));
            chkw("stream_data", rsp_data, shadow[c-2]);
         end else begin
            chk1("stream_gap", rsp_valid, 1'b0);
         end
      end
      chkw("stream_rd_count", 72'(rd_count), 72'd37);

      // Wrap with rsp_ready toggling; scoreboard keeps order
      sent = 0; got = 0; exp_q.delete();
      for (int c = 0; c < 80 && got < 10; c++) begin
         tick(); rsp_ready = (c % 2 == 0); req_valid = (sent < 10); req_addr = 6'(40 + sent); settle();
         if (rsp_valid && rsp_ready) begin
            chk1("wrap_expected_pending", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chkw("wrap_addr", 72'(rsp_addr), 72'(e));
               chkw("wrap_data", rsp_data, shadow[e]);
               got++;
            end
         end
         if (req_valid && req_ready) begin
            exp_q.push_back(40 + sent);
            sent++;
         end
      end
      chkw("wrap_received", 72'(got), 72'd10);
      tick(); req_valid = 1'b0; rsp_ready = 1'b1; settle();
      chk1("wrap_empty", rsp_valid, 1'b0);
      chkw("wrap_rd_count", 72'(rd_count), 72'd47);

      // Forwarding of a same-cycle write; a later write is not seen
      tick(); req_valid = 1'b1; req_addr = 6'd9;
      wr_en = 1'b1; wr_addr = 6'd9; wr_data = 72'hFF_0000_0000_0000_0001; settle();
      chk1("fwd_rd_en", mem_rd_en, 1'b1);
      tick(); req_valid = 1'b0; wr_data = 72'h2; settle();
      tick(); wr_en = 1'b0; settle();
      chk1("fwd_valid", rsp_valid, 1'b1);
      chkw("fwd_data", rsp_data, 72'hFF_0000_0000_0000_0001);
      chkw("fwd_addr", 72'(rsp_addr), 72'd9);
      shadow[9] = 72'h2;
      tick(); req_valid = 1'b1; req_addr = 6'd9;
      wr_en = 1'b1; wr_addr = 6'd11; wr_data = 72'h33; settle();
      tick(); req_valid = 1'b0; wr_en = 1'b0; settle();
      tick(); settle();
      chk1("nofwd_valid", rsp_valid, 1'b1);
      chkw("nofwd_data", rsp_data, 72'h2);
      shadow[11] = 72'h33;
      tick(); settle();
      chkw("fwd_rd_count", 72'(rd_count), 72'd49);

      // Reset with two entries queued and one read in flight
      tick(); rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 6'd1;
      tick(); req_addr = 6'd2;
      tick(); req_addr = 6'd3;
      tick(); req_valid = 1'b0; settle();
      chk1("pre_reset_valid", rsp_valid, 1'b1);
      chkw("pre_reset_addr", 72'(rsp_addr), 72'd1);
      chk1("pre_reset_ready", req_ready, 1'b1);
      #1 reset = 1'b0;
      #1;
      chk1("async_reset_valid", rsp_valid, 1'b0);
      chkw("async_reset_data", rsp_data, 72'd0);
      chkw("async_reset_addr", 72'(rsp_addr), 72'd0);
      chkw("async_reset_rd_count", 72'(rd_count), 72'd0);
      chk1("async_reset_ready", req_ready, 1'b0);
      tick(); reset = 1'b1; settle();
      chk1("post_reset_ready", req_ready, 1'b1);
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick(); settle();
         chk1("post_reset_no_stale", rsp_valid, 1'b0);
      end
      chkw("post_reset_rd_count", 72'(rd_count), 72'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
